// File: rtl/systolic_feed_if.sv
// Host and feeder-bank signals of the systolic feed controller.
// master = host/test side, slave = controller side.
interface systolic_feed_if #(
    parameter int ROWS       = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic                  reuse;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [ROWS-1:0][1:0]  ctrl_code;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ROWS-1:0]       row_valid;
    logic                  busy;
    logic                  done;

    modport master (
        output start, reuse, in_valid, in_data,
        input  in_ready, ctrl_code, wr_data, row_valid, busy, done
    );

    modport slave (
        input  start, reuse, in_valid, in_data,
        output in_ready, ctrl_code, wr_data, row_valid, busy, done
    );
endinterface

// File: rtl/systolic_feed_ctrl.sv
// Sequencer for a bank of ROWS shift registers feeding a systolic array:
// loads a row-major stream with WRITE codes, then issues skewed READ codes
// so row i enters the array i cycles after row 0. A reuse start replays
// the loaded operands, since a full READ pass rotates each row back home.
module systolic_feed_ctrl #(
    parameter int ROWS       = 4,
    parameter int LENGTH     = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    systolic_feed_if.slave  bus
);
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW   = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int FMAX = ROWS + LENGTH - 2;
    localparam int FW   = (FMAX > 0) ? $clog2(FMAX + 1) : 1;

    localparam logic [1:0] UPLOAD = 2'd0;
    localparam logic [1:0] WRITE  = 2'd2;
    localparam logic [1:0] READ   = 2'd3;

    typedef enum logic [1:0] {IDLE, LOAD, FEED, DRAIN} state_t;

    state_t                state;
    logic [RW-1:0]         row_cnt;
    logic [CW-1:0]         col_cnt;
    logic [FW-1:0]         f_cnt;
    logic                  loaded;
    logic [ROWS-1:0][1:0]  ctrl_code;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ROWS-1:0]       row_valid;
    logic                  done;
    logic [ROWS-1:0][1:0]  wr_codes;
    logic                  last_word;

    // Rows that are inside their READ window for feed step f.
    function automatic logic [ROWS-1:0] read_mask(input int f);
        logic [ROWS-1:0] m;
        for (int i = 0; i < ROWS; i++)
            m[i] = (f >= i) && (f <= i + LENGTH - 1);
        return m;
    endfunction

    function automatic logic [ROWS-1:0][1:0] read_codes(input int f);
        logic [ROWS-1:0][1:0] c;
        logic [ROWS-1:0]      m;
        m = read_mask(f);
        for (int i = 0; i < ROWS; i++)
            c[i] = m[i] ? READ : UPLOAD;
        return c;
    endfunction

    // WRITE pattern for the row currently being filled.
    always_comb begin
        wr_codes          = '0;
        wr_codes[row_cnt] = WRITE;
        last_word = (row_cnt == RW'(ROWS - 1)) && (col_cnt == CW'(LENGTH - 1));
    end

    // Run sequencer; every output code is registered for the following cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            row_cnt   <= '0;
            col_cnt   <= '0;
            f_cnt     <= '0;
            loaded    <= 1'b0;
            ctrl_code <= '0;
            wr_data   <= '0;
            row_valid <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    row_valid <= '0;
                    ctrl_code <= '0;
                    if (bus.start) begin
                        if (bus.reuse && loaded) begin
                            state     <= FEED;
                            f_cnt     <= '0;
                            ctrl_code <= read_codes(0);
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    row_valid <= '0;
                    ctrl_code <= '0;
                    if (bus.in_valid) begin
                        wr_data <= bus.in_data;
                        if (last_word) begin
                            // Last word's WRITE shares the first FEED cycle
                            // with row 0's READ; they target different rows.
                            state     <= FEED;
                            loaded    <= 1'b1;
                            row_cnt   <= '0;
                            col_cnt   <= '0;
                            f_cnt     <= '0;
                            ctrl_code <= wr_codes | read_codes(0);
                        end else begin
                            ctrl_code <= wr_codes;
                            if (col_cnt == CW'(LENGTH - 1)) begin
                                col_cnt <= '0;
                                row_cnt <= row_cnt + 1'b1;
                            end else begin
                                col_cnt <= col_cnt + 1'b1;
                            end
                        end
                    end
                end
                FEED: begin
                    // data_read of row i is valid one cycle after its READ.
                    row_valid <= read_mask(int'(f_cnt));
                    if (f_cnt == FW'(FMAX)) begin
                        state     <= DRAIN;
                        ctrl_code <= '0;
                    end else begin
                        f_cnt     <= f_cnt + 1'b1;
                        ctrl_code <= read_codes(int'(f_cnt) + 1);
                    end
                end
                default: begin
                    row_valid <= '0;
                    ctrl_code <= '0;
                    f_cnt     <= '0;
                    state     <= IDLE;
                    done      <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == LOAD);
    assign bus.busy      = (state != IDLE);
    assign bus.ctrl_code = ctrl_code;
    assign bus.wr_data   = wr_data;
    assign bus.row_valid = row_valid;
    assign bus.done      = done;
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Randomized bench for systolic_feed_ctrl. Expected outputs come from a
// run timeline: each accepted start/transfer schedules the per-cycle
// codes, valids, busy and done it implies. A shift-register bank model
// driven by the DUT's codes checks the fed words end to end.
module tb_systolic_feed_ctrl;
    localparam int R    = 4;
    localparam int L    = 4;
    localparam int DW   = 8;
    localparam int NW   = R * L;
    localparam int MAXC = 1024;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    systolic_feed_if #(.ROWS(R), .DATA_WIDTH(DW)) bus();

    systolic_feed_ctrl #(.ROWS(R), .LENGTH(L), .DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // per-cycle expectations, index = number of posedges so far
    logic [R-1:0][1:0] e_code  [MAXC];
    logic [R-1:0]      e_valid [MAXC];
    logic              e_busy  [MAXC];
    logic              e_ready [MAXC];
    logic              e_done  [MAXC];
    logic              e_wchk  [MAXC];
    logic [DW-1:0]     e_wr    [MAXC];

    int  cyc = 0;
    bit  m_loading = 0;
    bit  m_loaded = 0;
    int  m_n = 0;
    int  busy_until = -1;
    int  feed_t = -100;
    logic [DW-1:0] words [R][L];

    // shift_reg bank model
    logic [DW-1:0]     sr [R][L];
    logic [DW-1:0]     dr [R];
    logic [R-1:0][1:0] seen_code = '0;
    logic [DW-1:0]     seen_wr = '0;

    int passed = 0;
    int total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    endtask

    task automatic clear_from(input int c);
        for (int k = c; k < MAXC; k++) begin
            e_code[k] = '0; e_valid[k] = '0; e_busy[k] = 0; e_ready[k] = 0;
            e_done[k] = 0; e_wchk[k] = 0; e_wr[k] = '0;
        end
    endtask

    // Feed starting in cycle t: row i reads at steps i..i+L-1.
    task automatic sched_feed(input int t);
        feed_t = t;
        for (int f = 0; f <= R + L - 2; f++) begin
            e_busy[t + f] = 1;
            for (int i = 0; i < R; i++)
                if (f >= i && f <= i + L - 1) begin
                    e_code[t + f][i] = 2'd3;
                    e_valid[t + f + 1][i] = 1'b1;
                end
        end
        e_busy[t + R + L - 1] = 1;
        e_done[t + R + L] = 1;
        busy_until = t + R + L - 1;
    endtask

    task automatic step(input bit s, input bit r, input bit v, input bit rst);
        logic [DW-1:0] d;
        int j;
        d = DW'($urandom);
        bus.start = s; bus.reuse = r; bus.in_valid = v; bus.in_data = d;
        reset_n = !rst;
        @(posedge clk);
        cyc++;
        // shift_reg bank reacts to the codes of the cycle just ended
        for (int i = 0; i < R; i++) begin
            if (rst) begin
                dr[i] = '0;
                for (int k = 0; k < L; k++) sr[i][k] = '0;
            end else if (seen_code[i] == 2'd2) begin
                for (int k = 0; k < L - 1; k++) sr[i][k] = sr[i][k + 1];
                sr[i][L - 1] = seen_wr;
            end else if (seen_code[i] == 2'd3) begin
                dr[i] = sr[i][0];
                for (int k = 0; k < L - 1; k++) sr[i][k] = sr[i][k + 1];
                sr[i][L - 1] = dr[i];
            end
        end
        // controller model
        if (rst) begin
            m_loading = 0; m_loaded = 0; busy_until = -1; feed_t = -100;
            clear_from(cyc);
            e_wchk[cyc] = 1;
        end else if (m_loading) begin
            if (v) begin
                e_code[cyc][m_n / L] = 2'd2;
                e_wr[cyc] = d;
                e_wchk[cyc] = 1;
                words[m_n / L][m_n % L] = d;
                m_n++;
            end
            if (m_n == NW) begin
                m_loading = 0; m_loaded = 1;
                sched_feed(cyc);
            end else begin
                e_busy[cyc] = 1; e_ready[cyc] = 1;
            end
        end else if (s && (cyc - 1 > busy_until)) begin
            if (r && m_loaded) sched_feed(cyc);
            else begin
                m_loading = 1; m_n = 0;
                e_busy[cyc] = 1; e_ready[cyc] = 1;
            end
        end
        @(negedge clk);
        chk("busy",      32'(bus.busy),      32'(e_busy[cyc]));
        chk("in_ready",  32'(bus.in_ready),  32'(e_ready[cyc]));
        chk("done",      32'(bus.done),      32'(e_done[cyc]));
        chk("row_valid", 32'(bus.row_valid), 32'(e_valid[cyc]));
        chk("ctrl_code", 32'(bus.ctrl_code), 32'(e_code[cyc]));
        if (e_wchk[cyc]) chk("wr_data", 32'(bus.wr_data), 32'(e_wr[cyc]));
        for (int i = 0; i < R; i++)
            if (e_valid[cyc][i] && feed_t >= 0) begin
                j = cyc - (feed_t + 1 + i);
                if (j >= 0 && j < L) chk("row_data", 32'(dr[i]), 32'(words[i][j]));
            end
        seen_code = bus.ctrl_code;
        seen_wr = bus.wr_data;
    endtask

    initial begin
        bus.start = 0; bus.reuse = 0; bus.in_valid = 0; bus.in_data = '0;
        clear_from(0);
        for (int i = 0; i < R; i++) begin
            dr[i] = '0;
            for (int k = 0; k < L; k++) begin sr[i][k] = '0; words[i][k] = '0; end
        end
        // reset held with start asserted
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        // reuse before any load falls back to LOAD; stream with valid held high
        step(1, 1, 1, 0);
        for (int k = 0; k < 30; k++) step(0, 0, 1, 0);
        // replay the loaded operands
        step(1, 1, 0, 0);
        for (int k = 0; k < 12; k++) step(0, 0, 1, 0);
        // backpressure: valid toggles every cycle
        step(1, 0, 0, 0);
        for (int k = 0; k < 45; k++) step(0, 0, k[0], 0);
        // reset after 6 words, then reload with random stalls and stray starts
        step(1, 0, 1, 0);
        for (int k = 0; k < 6; k++) step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        for (int k = 0; k < 80; k++)
            step($urandom_range(3) == 0, $urandom_range(1) == 1, $urandom_range(1) == 1, 0);
        // free-running random traffic with rare resets
        for (int k = 0; k < 300; k++)
            step($urandom_range(3) == 0, $urandom_range(1) == 1,
                 $urandom_range(2) != 0, $urandom_range(96) == 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/systolic_feed_ctrl.md
# systolic_feed_ctrl

Sequencing controller for the bank of `ROWS` `shift_reg` instances that feed the row inputs of the systolic array. It accepts a row-major operand stream from the host over a valid/ready handshake and steers it into the row registers with WRITE codes. It then issues skewed READ codes so that row `i` enters the array `i` cycles after row 0, and reports the matching per-row data-valid timing. A reuse start replays the already-loaded operands without reloading them, because a full READ pass rotates each register's contents back to their original order.

## Interface

Parameters:
- `ROWS`, 4, number of row feeders (shift_reg instances).
- `LENGTH`, 4, words per row; equals each shift_reg `LENGTH`.
- `DATA_WIDTH`, 8, word width.

Ports:
- `clk`  in  1  single clock, all logic on posedge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a run; sampled in IDLE only.
- `reuse`  in  1  qualifies `start`: skip LOAD and feed the existing contents.
- `in_valid`  in  1  host word valid.
- `in_ready`  out  1  controller accepts a word; high only in LOAD.
- `in_data`  in  DATA_WIDTH  host word, row-major order.
- `ctrl_code`  out  [ROWS][2]  per-row shift_reg code: 0 UPLOAD (idle), 2 WRITE, 3 READ; code 1 is never driven.
- `wr_data`  out  DATA_WIDTH  shared `data_write` bus to all rows.
- `row_valid`  out  ROWS  bit i high when row i `data_read` holds a fed word.
- `busy`  out  1  high in LOAD, FEED and DRAIN.
- `done`  out  1  one-cycle pulse when a run completes.

## Operation

- States: IDLE, LOAD, FEED, DRAIN.
- IDLE:
  - `start & reuse & loaded` goes to FEED.
  - `start` with any other condition goes to LOAD.
  - `start` is ignored in every other state.
- LOAD:
  - `in_ready = 1`; a transfer occurs when `in_valid & in_ready`.
  - Transfer k (0-based) targets row `k / LENGTH`.
  - Counters are `row_cnt` (width clog2(ROWS), min 1) and `col_cnt` (width clog2(LENGTH), min 1). `col_cnt` wraps at LENGTH-1 and increments `row_cnt`.
  - After transfer number ROWS*LENGTH: go to FEED, set `loaded = 1`, clear counters.
  - Word order: the first word written to a row is the first word read from it.
- FEED:
  - Counter f runs from 0 to ROWS+LENGTH-2, one value per cycle.
  - Row i gets READ when i ≤ f ≤ i+LENGTH-1; otherwise UPLOAD.
  - After f = ROWS+LENGTH-2, go to DRAIN.
- DRAIN:
  - Lasts one cycle; all codes are UPLOAD.
  - Then go to IDLE with `done = 1` for that first IDLE cycle.
- `loaded` is cleared only by reset.
- Reset at any point, including mid-LOAD or mid-FEED:
  - Next edge returns all state and outputs to reset values and clears `loaded`.
  - The shift_regs are on the same reset, so their contents clear too.

## Timing

- Reset values: state IDLE; all `ctrl_code` = 0; `wr_data` = 0; `in_ready` = 0; `row_valid` = 0; `busy` = 0; `done` = 0; all counters and `loaded` = 0.
- `ctrl_code` and `wr_data` are registered. Transfer at edge t gives `ctrl_code[row] = WRITE` and `wr_data = in_data` during cycle t+1, so the shift_reg captures at edge t+2. All other rows show UPLOAD in cycle t+1. Cycles with no transfer show UPLOAD on every row.
- `in_ready` is a decode of state (combinational), so it drops in the first FEED cycle.
- `start` at edge t puts the block in LOAD/FEED in cycle t+1, with `busy` high from t+1.
- The first FEED cycle presents f = 0: row 0 shows READ in that same cycle.
- `row_valid[i]` is the READ condition for row i delayed one cycle, matching the registered `data_read`. Row ROWS-1 is valid during DRAIN.
- Run length after start:
  - Reuse: ROWS+LENGTH cycles busy.
  - Load with no stalls: ROWS*LENGTH + ROWS+LENGTH cycles busy.
- `start` and `reuse` have no effect in the `done` cycle's own decision. A `start` in the `done` cycle is accepted, because the block is already in IDLE.

## Test plan

- Reset: hold `reset_n` = 0 for 2 cycles with `start` = 1 → all outputs at reset values; `busy` = 0.
- Full load and feed, ROWS=4, LENGTH=4, words 1..16 with `in_valid` held high:
  - `ctrl_code` shows WRITE on row 0 for 4 cycles, then rows 1, 2, 3 in turn.
  - `in_ready` falls after word 16.
  - With shift_regs attached, row i `data_read` gives {4i+1..4i+4} under `row_valid[i]`, starting i cycles after row 0.
  - `done` pulses after DRAIN.
- Backpressure: toggle `in_valid` every cycle during LOAD → WRITE only in the cycle after each accepted word, UPLOAD otherwise; the 16 words still land in the correct rows.
- Reuse: after the full run, `start = 1`, `reuse = 1` → no LOAD and `in_ready` stays 0; FEED data and `row_valid` are identical to the previous run; busy for 8 cycles.
- Reuse before any load: `start = 1`, `reuse = 1` right after reset → enters LOAD.
- Reset mid-LOAD after 6 words, plus `start` pulsed while busy:
  - Reset returns all outputs to reset values, and the next load starts at row 0, column 0.
  - `start` pulsed during FEED is ignored, and the run completes normally.
